rv32i_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, byte-masked, synchronous-read memory between the core's instruction-fetch port and its data load/store port. It sits between `rv32i_core` and a unified instruction/data RAM, so a single memory macro can replace separate ROM and RAM arrays. Each port uses a req/gnt handshake. Read data returns one cycle after the grant with an `rvalid` strobe, and back-to-back transactions run at full throughput.

---
 rtl/rv32i_mem_pkg.sv | 25 ++
 rtl/rv32i_arb2_pick.sv | 29 ++
 rtl/rv32i_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_pkg
// Purpose  : Shared types and constants for the rv32i memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_mem_pkg;

  // Which read response (if any) the memory returns on the current cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_I    = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_t;

  // Side favoured on the next request conflict.
  typedef enum logic {
    PRI_I = 1'b0,
    PRI_D = 1'b1
  } arb_pri_t;

  localparam int MEM_WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/rv32i_arb2_pick.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_arb2_pick
// Purpose  : Two-way one-hot grant picker. req[0] = fetch, req[1] = data.
//            A lone request always wins; on a conflict the side named by
//            pri wins.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_arb2_pick
  import rv32i_mem_pkg::*;
(
  input  logic [1:0] req,
  input  arb_pri_t   pri,
  output logic [1:0] gnt
);

  // One-hot grant selection from the request pair and the priority hint
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (pri == PRI_I) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_arbiter
// Purpose  : Shares one single-port, byte-masked, synchronous-read memory
//            between the instruction-fetch and data ports of rv32i_core.
//            req/gnt handshake, read data one cycle after grant, full
//            throughput.
// Options  : RV32I_MEM_ARB_RR_EN - defined: round-robin on conflicts;
//            undefined: data port has fixed priority (no pointer register).
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // fetch port
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  output logic                           i_gnt,
  output logic                           i_rvalid,
  output logic [31:0]                    i_rdata,
  // data port
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [31:0]                    d_wdata,
  input  logic [3:0]                     d_wmask,
  output logic                           d_gnt,
  output logic                           d_rvalid,
  output logic [31:0]                    d_rdata,
  // memory port
  output logic                           m_en,
  output logic                           m_we,
  output logic [$clog2(MEM_BYTES)-3:0]   m_addr,
  output logic [31:0]                    m_wdata,
  output logic [3:0]                     m_wmask,
  input  logic [31:0]                    m_rdata
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int OFS_W = $clog2(MEM_WORD_BYTES);

  logic [1:0] req_v;
  logic [1:0] gnt;
  arb_pri_t   pri;
  rsp_state_t state;
  rsp_state_t state_nxt;

  // Requests are masked while reset is asserted so no grant or access
  // can leak out combinationally during reset.
  assign req_v = {d_req & rst_n, i_req & rst_n};

`ifdef RV32I_MEM_ARB_RR_EN
  arb_pri_t pri_q;

  // Round-robin pointer: after each grant, favour the other side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pri_q <= PRI_I;
    else if (gnt[0]) pri_q <= PRI_D;
    else if (gnt[1]) pri_q <= PRI_I;
  end

  assign pri = pri_q;
`else
  // Fixed priority: data always wins so a stalled load/store never waits.
  assign pri = PRI_D;
`endif

  rv32i_arb2_pick u_pick (
    .req (req_v),
    .pri (pri),
    .gnt (gnt)
  );

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // Memory port driven from whichever side won this cycle; zero when idle
  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_wmask = 4'b0000;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_addr  = d_addr[IDX_W-1:OFS_W];
      m_wdata = d_wdata;
      if (d_we) m_wmask = d_wmask;
    end else if (i_gnt) begin
      m_addr  = i_addr[IDX_W-1:OFS_W];
    end
  end

  // Response tracker register; reset drops any outstanding read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RSP_NONE;
    else        state <= state_nxt;
  end

  // Next response owner follows this cycle's read grant (stores return nothing)
  always_comb begin
    state_nxt = RSP_NONE;
    if (i_gnt)              state_nxt = RSP_I;
    else if (d_gnt && !d_we) state_nxt = RSP_D;
  end

  assign i_rvalid = (state == RSP_I);
  assign d_rvalid = (state == RSP_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  // Byte offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mem_arbiter
// Purpose  : Scoreboard bench for rv32i_mem_arbiter with a behavioural
//            synchronous-read, byte-masked memory model.
// Options  : RV32I_MEM_ARB_RR_EN selects the expected conflict pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wmask = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata = '0;

  logic [31:0] mem [0:1023];

  typedef struct {
    bit          is_d;
    logic [9:0]  addr;
    bit          we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          due;
  } gexp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          due;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.ADDR_W(32), .MEM_BYTES(4096)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wmask  (d_wmask),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wmask  (m_wmask),
    .m_rdata  (m_rdata)
  );

  // Memory model: synchronous read, byte-masked write
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop expected grants / read responses whenever the DUT shows one
  always @(negedge clk) begin
    while (gq.size() > 0 && gq[0].due < cyc) begin
      check("gnt_missing", 64'(0), 64'(gq[0].due));
      void'(gq.pop_front());
    end
    while (rq.size() > 0 && rq[0].due < cyc) begin
      check("rvalid_missing", 64'(0), 64'(rq[0].due));
      void'(rq.pop_front());
    end
    if (i_gnt || d_gnt) begin
      if (gq.size() == 0) begin
        check("gnt_unexpected", {62'd0, i_gnt, d_gnt}, 64'd0);
      end else begin
        gexp_t e;
        e = gq.pop_front();
        check("gnt_cycle", 64'(cyc), 64'(e.due));
        check("gnt_port", {62'd0, i_gnt, d_gnt}, e.is_d ? 64'd1 : 64'd2);
        check("m_en_we", {62'd0, m_en, m_we}, {62'd0, 1'b1, e.we});
        check("m_addr", 64'(m_addr), 64'(e.addr));
        check("m_wmask", 64'(m_wmask), 64'(e.mask));
        if (e.we) check("m_wdata", 64'(m_wdata), 64'(e.wdata));
      end
    end
    if (i_rvalid || d_rvalid) begin
      if (rq.size() == 0) begin
        check("rvalid_unexpected", {62'd0, i_rvalid, d_rvalid}, 64'd0);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        check("rvalid_cycle", 64'(cyc), 64'(r.due));
        check("rvalid_port", {62'd0, i_rvalid, d_rvalid}, r.is_d ? 64'd1 : 64'd2);
        check("rdata", 64'(i_rvalid ? i_rdata : d_rdata), 64'(r.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic exp_fetch(input logic [31:0] a, input logic [31:0] data);
    gq.push_back('{is_d: 1'b0, addr: a[11:2], we: 1'b0, mask: 4'b0, wdata: 32'd0, due: cyc});
    rq.push_back('{is_d: 1'b0, data: data, due: cyc + 1});
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [31:0] data);
    gq.push_back('{is_d: 1'b1, addr: a[11:2], we: 1'b0, mask: 4'b0, wdata: 32'd0, due: cyc});
    rq.push_back('{is_d: 1'b1, data: data, due: cyc + 1});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {58'd0, i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid}, 64'd0);
    check({tag, "_wmask"}, 64'(m_wmask), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 32'd0;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_0193;
    mem[4] = 32'h0050_0093;

    // Reset with requests asserted: nothing may be granted
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check_reset_outputs("reset");
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Lone fetch of word 4
    i_req = 1'b1; i_addr = 32'h10;
    exp_fetch(32'h10, 32'h0050_0093);
    tick();
    idle();
    tick();

    // Store with low-half mask, then load the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD; d_wmask = 4'b0011;
    gq.push_back('{is_d: 1'b1, addr: 10'd8, we: 1'b1, mask: 4'b0011, wdata: 32'hAABB_CCDD, due: cyc});
    tick();
    d_we = 1'b0;
    exp_load(32'h20, 32'h0000_CCDD);
    tick();
    idle();
    repeat (2) tick();

    // Back-to-back fetches, responses must arrive without a bubble
    i_req = 1'b1;
    i_addr = 32'h0; exp_fetch(32'h0, 32'h0000_0013); tick();
    i_addr = 32'h4; exp_fetch(32'h4, 32'h0010_0113); tick();
    i_addr = 32'h8; exp_fetch(32'h8, 32'h0020_0193); tick();
    idle();
    repeat (2) tick();

    // Fresh reset so the conflict starts from the reset pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Sustained conflict for four cycles
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
`ifdef RV32I_MEM_ARB_RR_EN
      if (k % 2 == 0) exp_fetch(32'h0, 32'h0000_0013);
      else            exp_load(32'h20, 32'h0000_CCDD);
`else
      exp_load(32'h20, 32'h0000_CCDD);
`endif
      tick();
    end
    idle();
    repeat (2) tick();

    // Reset asserted while a load is outstanding: the response is dropped
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    gq.push_back('{is_d: 1'b1, addr: 10'd8, we: 1'b0, mask: 4'b0, wdata: 32'd0, due: cyc});
    @(negedge clk); #1;
    rst_n = 1'b0;
    i_req = 1'b1; d_we = 1'b1; d_wmask = 4'hF;
    @(negedge clk); #2;
    check_reset_outputs("midreset");
    tick();
    idle();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk); #2;
    check("post_reset_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);

    repeat (2) tick();
    check("gq_drained", 64'(gq.size()), 64'd0);
    check("rq_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
